// File: rtl/dram16k4_pkg.sv
// dram16k4_pkg: shared widths, FSM states and grant codes for the 4416 DRAM arbiter
package dram16k4_pkg;
  localparam int ADDR_W = 14;
  localparam int ROW_W = 8;
  localparam int COL_W = 6;
  localparam int DATA_W = 4;
  typedef enum logic [2:0] {IDLE, ROW, COL, ACC, PRE, RFR_ROW} state_t;
  typedef enum logic [1:0] {NONE, VID, CPU, RFR} gnt_t;
endpackage

// File: rtl/dram16k4_arbiter_if.sv
// dram16k4_arbiter_if: video/CPU request ports and DRAM pins; slave = arbiter, master = requesters and DRAM
interface dram16k4_arbiter_if;
  import dram16k4_pkg::*;
  logic vid_req, vid_ack, cpu_req, cpu_wr, cpu_ack;
  logic ras_n, cas_n, wr_n, rd_n, busy;
  logic [ADDR_W-1:0] vid_addr, cpu_addr;
  logic [DATA_W-1:0] vid_data, cpu_din, cpu_dout, dram_din, dram_dout;
  logic [ROW_W-1:0] dram_addr;
  modport slave (
    input vid_req, vid_addr, cpu_req, cpu_wr, cpu_addr, cpu_din, dram_dout,
    output vid_ack, vid_data, cpu_ack, cpu_dout, dram_addr, dram_din, ras_n, cas_n, wr_n, rd_n, busy
  );
  modport master (
    output vid_req, vid_addr, cpu_req, cpu_wr, cpu_addr, cpu_din, dram_dout,
    input vid_ack, vid_data, cpu_ack, cpu_dout, dram_addr, dram_din, ras_n, cas_n, wr_n, rd_n, busy
  );
endinterface

// File: rtl/dram16k4_refresh_timer.sv
// dram16k4_refresh_timer: refresh period counter, pending flag and RAS-only row counter
module dram16k4_refresh_timer #(
  parameter int PERIOD = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       take,
  output logic       pend,
  output logic [7:0] row
);
  logic [15:0] cnt;
  logic expire;
  assign expire = cnt == 16'(PERIOD - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      pend <= 1'b0;
      row <= '0;
    end else begin
      cnt <= expire ? '0 : cnt + 16'd1;
      pend <= expire || (pend && !take);
      row <= take ? row + 8'd1 : row;
    end
  end
endmodule

// File: rtl/dram16k4_arbiter.sv
// dram16k4_arbiter: 4416 DRAM sequencer/arbiter (video > CPU); refresh enabled by DRAM16K4_REFRESH_EN
module dram16k4_arbiter #(
  parameter int REFRESH_PERIOD = 128
) (
  input logic i_MCLK,
  input logic i_RST_n,
  dram16k4_arbiter_if.slave bus
);
  import dram16k4_pkg::*;
  state_t state, nxt_state;
  gnt_t gnt, nxt_gnt, win;
  logic [ADDR_W-1:0] addr_q, nxt_addr;
  logic wr_q, nxt_wr, arb, done_vid, done_cpu, mask_vid, mask_cpu;
  logic rfr_pend, rfr_take;
  logic [ROW_W-1:0] rfr_row;
`ifdef DRAM16K4_REFRESH_EN
  dram16k4_refresh_timer #(.PERIOD(REFRESH_PERIOD)) u_rfr (
    .clk(i_MCLK), .rst_n(i_RST_n), .take(rfr_take), .pend(rfr_pend), .row(rfr_row)
  );
`else
  logic unused_rfr;
  assign rfr_pend = 1'b0;
  assign rfr_row = '0;
  assign unused_rfr = rfr_take | (REFRESH_PERIOD != 0);
`endif
  // a port is masked through its PRE and ACK cycles so a still-held request is not served twice
  always_comb begin
    arb = state == IDLE || state == PRE;
    done_vid = state == PRE && gnt == VID;
    done_cpu = state == PRE && gnt == CPU;
    mask_vid = done_vid || bus.vid_ack;
    mask_cpu = done_cpu || bus.cpu_ack;
    win = rfr_pend ? RFR : (bus.vid_req && !mask_vid) ? VID : (bus.cpu_req && !mask_cpu) ? CPU : NONE;
    rfr_take = arb && win == RFR;
    nxt_gnt = arb ? win : gnt;
    nxt_addr = !arb ? addr_q : win == VID ? bus.vid_addr : win == CPU ? bus.cpu_addr : addr_q;
    nxt_wr = arb ? (win == CPU && bus.cpu_wr) : wr_q;
    nxt_state = arb ? (win == NONE ? IDLE : win == RFR ? RFR_ROW : ROW) :
                state == ROW ? COL : state == COL ? ACC : PRE;
  end
  always_ff @(posedge i_MCLK) begin
    if (!i_RST_n) begin
      state <= IDLE;
      gnt <= NONE;
      addr_q <= '0;
      wr_q <= 1'b0;
      bus.ras_n <= 1'b1;
      bus.cas_n <= 1'b1;
      bus.wr_n <= 1'b1;
      bus.rd_n <= 1'b1;
      bus.dram_addr <= '0;
      bus.dram_din <= '0;
      bus.vid_ack <= 1'b0;
      bus.cpu_ack <= 1'b0;
      bus.vid_data <= '0;
      bus.cpu_dout <= '0;
      bus.busy <= 1'b0;
    end else begin
      state <= nxt_state;
      gnt <= nxt_gnt;
      addr_q <= nxt_addr;
      wr_q <= nxt_wr;
      bus.ras_n <= nxt_state == IDLE || nxt_state == PRE;
      bus.cas_n <= !(nxt_state == COL || nxt_state == ACC);
      bus.wr_n <= !(nxt_state == ACC && nxt_wr);
      bus.rd_n <= !(nxt_state == ACC && !nxt_wr);
      bus.dram_addr <= nxt_state == ROW ? nxt_addr[ROW_W-1:0] :
                       nxt_state == COL ? {1'b0, nxt_addr[ADDR_W-1:ROW_W], 1'b0} :
                       nxt_state == RFR_ROW ? rfr_row : bus.dram_addr;
      bus.dram_din <= nxt_state == ROW ? bus.cpu_din : bus.dram_din;
      bus.vid_ack <= done_vid;
      bus.cpu_ack <= done_cpu;
      bus.vid_data <= done_vid ? bus.dram_dout : bus.vid_data;
      bus.cpu_dout <= (done_cpu && !wr_q) ? bus.dram_dout : bus.cpu_dout;
      bus.busy <= nxt_state != IDLE;
    end
  end
endmodule

// File: tb/tb_dram16k4_arbiter.sv
// tb_dram16k4_arbiter: directed checks of the DRAM arbiter against a behavioural 4416 model
module tb_dram16k4_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  dram16k4_arbiter_if bus();
  dram16k4_arbiter #(.REFRESH_PERIOD(16)) dut (.i_MCLK(clk), .i_RST_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  bit [3:0] mem [16384];
  logic [7:0] row_l;
  logic [5:0] col_l;
  bit [3:0] dout_q;
  logic [3:0] str;
  assign bus.dram_dout = dout_q;
  assign str = {bus.ras_n, bus.cas_n, bus.wr_n, bus.rd_n};
  // DRAM model decodes the pins only: row on RAS-only cycles, column while CAS is low
  always @(posedge clk) begin
    if (!bus.ras_n && bus.cas_n) row_l <= bus.dram_addr;
    if (!bus.cas_n) col_l <= bus.dram_addr[6:1];
    if (!bus.wr_n) mem[{col_l, row_l}] <= bus.dram_din;
    if (!bus.rd_n) dout_q <= mem[{col_l, row_l}];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cpu_op(input logic wr, input logic [13:0] a, input logic [3:0] d, input int exp_lat);
    int lat;
    lat = 0;
    bus.cpu_wr = wr;
    bus.cpu_addr = a;
    bus.cpu_din = d;
    bus.cpu_req = 1'b1;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      if (k == exp_lat - 2) chk("acc_strobe", str, wr ? 4'h1 : 4'h2);
      if (bus.cpu_ack) lat = k;
    end
    bus.cpu_req = 1'b0;
    chk("cpu_lat", lat, exp_lat);
    @(negedge clk);
    chk("ack_pulse", bus.cpu_ack, 0);
  endtask
  initial begin
    bus.vid_req = 1'b0;
    bus.vid_addr = '0;
    bus.cpu_req = 1'b0;
    bus.cpu_wr = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_din = '0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", str, 4'hF);
    chk("rst_addr", bus.dram_addr, 0);
    chk("rst_din", bus.dram_din, 0);
    chk("rst_vdata", bus.vid_data, 0);
    chk("rst_cdout", bus.cpu_dout, 0);
    chk("rst_acks", {bus.vid_ack, bus.cpu_ack}, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
`ifndef DRAM16K4_REFRESH_EN
    begin
      int va, ca, rh, rbad, acks;
      logic [3:0] s5;
      bus.cpu_wr = 1'b1;
      bus.cpu_addr = 14'h2A5C;
      bus.cpu_din = 4'hB;
      bus.cpu_req = 1'b1;
      @(negedge clk);
      chk("wr_row_str", str, 4'h7);
      chk("wr_row_addr", bus.dram_addr, 8'h5C);
      chk("wr_din", bus.dram_din, 4'hB);
      chk("wr_busy", bus.busy, 1);
      @(negedge clk);
      chk("wr_col_str", str, 4'h3);
      chk("wr_col_addr", bus.dram_addr, 8'h54);
      @(negedge clk);
      chk("wr_acc_str", str, 4'h1);
      @(negedge clk);
      chk("wr_pre_str", str, 4'hF);
      @(negedge clk);
      chk("wr_ack", {bus.vid_ack, bus.cpu_ack}, 2'b01);
      bus.cpu_req = 1'b0;
      @(negedge clk);
      chk("wr_ack_end", bus.cpu_ack, 0);
      chk("wr_idle", bus.busy, 0);
      cpu_op(1'b0, 14'h2A5C, 4'h0, 5);
      chk("rd_data", bus.cpu_dout, 4'hB);
      cpu_op(1'b1, 14'h0001, 4'h5, 5);
      cpu_op(1'b0, 14'h0001, 4'h0, 5);
      chk("rd_data2", bus.cpu_dout, 4'h5);
      va = 0;
      ca = 0;
      s5 = '0;
      bus.vid_addr = 14'h2A5C;
      bus.cpu_addr = 14'h0001;
      bus.cpu_wr = 1'b0;
      bus.vid_req = 1'b1;
      bus.cpu_req = 1'b1;
      for (int k = 1; k <= 14; k++) begin
        @(negedge clk);
        if (k == 5) s5 = str;
        if (bus.vid_ack) begin va = k; bus.vid_req = 1'b0; end
        if (bus.cpu_ack) begin ca = k; bus.cpu_req = 1'b0; end
      end
      bus.vid_req = 1'b0;
      bus.cpu_req = 1'b0;
      chk("both_vid_ack", va, 5);
      chk("both_cpu_ack", ca, 9);
      chk("both_no_gap", s5, 4'h7);
      chk("both_vdata", bus.vid_data, 4'hB);
      chk("both_cdata", bus.cpu_dout, 4'h5);
      rh = 0;
      rbad = 0;
      acks = 0;
      bus.vid_addr = 14'h0001;
      bus.cpu_addr = 14'h2A5C;
      bus.vid_req = 1'b1;
      bus.cpu_req = 1'b1;
      for (int k = 1; k <= 44; k++) begin
        @(negedge clk);
        if (k <= 40 && bus.ras_n) rh++;
        if (k <= 40 && bus.ras_n != (k % 4 == 0)) rbad++;
        if (bus.vid_ack || bus.cpu_ack) begin
          chk("alt_order", {bus.vid_ack, bus.cpu_ack}, (acks % 2 == 0) ? 2'b10 : 2'b01);
          acks++;
        end
        if (k == 40) begin bus.vid_req = 1'b0; bus.cpu_req = 1'b0; end
      end
      chk("cont_acks", acks, 10);
      chk("cont_ras_high", rh, 10);
      chk("cont_ras_phase", rbad, 0);
      chk("cont_vdata", bus.vid_data, 4'h5);
      chk("cont_cdata", bus.cpu_dout, 4'hB);
      cpu_op(1'b1, 14'h0333, 4'h3, 5);
      bus.cpu_wr = 1'b1;
      bus.cpu_addr = 14'h0333;
      bus.cpu_din = 4'h9;
      bus.cpu_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("abort_col", str, 4'h3);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_strobes", str, 4'hF);
      chk("abort_busy", bus.busy, 0);
      chk("abort_ack", bus.cpu_ack, 0);
      rst_n = 1'b1;
      bus.cpu_req = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (bus.cpu_ack) chk("abort_late_ack", bus.cpu_ack, 0);
      end
      chk("abort_mem", mem[14'h0333], 4'h3);
      cpu_op(1'b0, 14'h0333, 4'h0, 5);
      chk("abort_rd", bus.cpu_dout, 4'h3);
    end
`else
    begin
      int last, n, clow;
      last = -1;
      n = 0;
      clow = 0;
      for (int k = 1; k <= 80 && n < 4; k++) begin
        @(negedge clk);
        if (!bus.cas_n) clow++;
        if (!bus.ras_n) begin
          chk("rfr_cas", bus.cas_n, 1);
          chk("rfr_addr", bus.dram_addr, n);
          if (last >= 0) chk("rfr_gap", k - last, 16);
          last = k;
          n++;
        end
      end
      chk("rfr_count", n, 4);
      chk("rfr_cas_low", clow, 0);
      repeat (15) @(negedge clk);
      cpu_op(1'b0, 14'h0000, 4'h0, 7);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
